// File: rtl/mpeg_start_code_scanner_if.sv
// rtl/mpeg_start_code_scanner_if.sv - byte-in / tagged-byte-out bundle for the start-code scanner
interface mpeg_start_code_scanner_if #(
  parameter int CNT_W = 32
);
  logic [7:0]       byte_in;
  logic             byte_in_en;
  logic             stream_end;
  logic [7:0]       byte_out;
  logic             byte_out_en;
  logic             sc_start;
  logic [7:0]       sc_code;
  logic             sc_video;
  logic             done;
  logic [CNT_W-1:0] sc_cnt;
  logic [CNT_W-1:0] video_sc_cnt;

  modport master (
    output byte_in, byte_in_en, stream_end,
    input  byte_out, byte_out_en, sc_start, sc_code, sc_video, done, sc_cnt, video_sc_cnt
  );

  modport slave (
    input  byte_in, byte_in_en, stream_end,
    output byte_out, byte_out_en, sc_start, sc_code, sc_video, done, sc_cnt, video_sc_cnt
  );
endinterface

// File: rtl/mpeg_start_code_scanner.sv
// rtl/mpeg_start_code_scanner.sv - MPEG 00 00 01 xx start-code tagger with 4-byte delay window
module mpeg_start_code_scanner #(
  parameter logic [7:0] VIDEO_LO = 8'hE0,
  parameter logic [7:0] VIDEO_HI = 8'hEF,
  parameter int         CNT_W    = 32
) (
  input logic                       clk,
  input logic                       rst,
  input logic                       clk_en,
  mpeg_start_code_scanner_if.slave  sif
);

  logic [3:0][7:0] win;
  logic [2:0]      fill;
  logic            end_latched;

  logic            accept;
  logic            flush;
  logic            emit;
  logic [7:0]      oldest;
  logic            flag;
  logic            is_video;

  assign accept = sif.byte_in_en && !end_latched;
  assign flush  = end_latched && (fill != 3'd0);
  assign emit   = (accept && (fill == 3'd4)) || flush;

  // Valid bytes sit in win[0..fill-1]; the oldest one is the next to leave.
  always_comb begin
    oldest = win[3];
    case (fill)
      3'd1:    oldest = win[0];
      3'd2:    oldest = win[1];
      3'd3:    oldest = win[2];
      default: oldest = win[3];
    endcase
  end

  // A prefix can only be recognised when three newer bytes are present.
  assign flag     = (fill == 3'd4) && (win[3] == 8'h00) && (win[2] == 8'h00) && (win[1] == 8'h01);
  assign is_video = (win[0] >= VIDEO_LO) && (win[0] <= VIDEO_HI);

  always_ff @(posedge clk) begin
    if (rst) begin
      win              <= '0;
      fill             <= 3'd0;
      end_latched      <= 1'b0;
      sif.byte_out     <= 8'h00;
      sif.byte_out_en  <= 1'b0;
      sif.sc_start     <= 1'b0;
      sif.sc_code      <= 8'h00;
      sif.sc_video     <= 1'b0;
      sif.done         <= 1'b0;
      sif.sc_cnt       <= '0;
      sif.video_sc_cnt <= '0;
    end else begin
      sif.byte_out_en <= 1'b0;
      sif.sc_start    <= 1'b0;
      sif.sc_video    <= 1'b0;
      if (clk_en) begin
        if (emit) begin
          sif.byte_out_en <= 1'b1;
          sif.byte_out    <= oldest;
          sif.sc_start    <= flag;
          if (flag) begin
            sif.sc_code  <= win[0];
            sif.sc_video <= is_video;
            sif.sc_cnt   <= sif.sc_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (is_video)
              sif.video_sc_cnt <= sif.video_sc_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end

        // Flush leaves the window in place and just shrinks fill toward the newest byte.
        if (accept) begin
          win  <= {win[2:0], sif.byte_in};
          fill <= (fill == 3'd4) ? 3'd4 : fill + 3'd1;
        end else if (flush) begin
          fill <= fill - 3'd1;
        end

        if (sif.stream_end)
          end_latched <= 1'b1;

        if (end_latched && (fill == 3'd0))
          sif.done <= 1'b1;
      end
    end
  end

endmodule

// File: doc/mpeg_start_code_scanner.md
Name: mpeg_start_code_scanner

Overview:
- Byte-stream front end sitting directly upstream of the bhargava core input (mpeg_in / mpeg_in_en / stream_end).
- Scans the raw MPEG byte stream for start-code prefixes (00 00 01 xx) and tags the first prefix byte with the code value and a video flag.
- Passes every byte through unchanged in order, and flushes its window at stream end.
- Gives the downstream stages start-code alignment and per-stream start-code statistics.

Parameters:
- VIDEO_LO, 8'hE0, lowest stream_id treated as video PES.
- VIDEO_HI, 8'hEF, highest stream_id treated as video PES.
- CNT_W, 32, width of statistics counters.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- clk_en  in  1  global enable; when low all state holds, outputs hold except byte_out_en/sc_start (forced 0)
- byte_in  in  8  input byte
- byte_in_en  in  1  byte_in valid; always accepted (no backpressure)
- stream_end  in  1  level/pulse: no more input bytes after this cycle's byte
- byte_out  out  8  output byte (same order as input)
- byte_out_en  out  1  byte_out valid, one-cycle qualifier
- sc_start  out  1  with byte_out_en: this byte is the first 00 of a 00 00 01 prefix
- sc_code  out  8  code byte following the prefix; valid when sc_start=1, else holds
- sc_video  out  1  sc_start && VIDEO_LO<=sc_code<=VIDEO_HI
- done  out  1  sticky: stream_end seen and all bytes emitted
- sc_cnt  out  CNT_W  total start codes detected
- video_sc_cnt  out  CNT_W  start codes with sc_video=1

Behaviour:
- Reset (rst=1 at clk edge, overrides clk_en):
  - byte_out=0, byte_out_en=0, sc_start=0, sc_code=0, sc_video=0, done=0, counters=0.
  - Window empty (fill=0), end_latched=0.
  - Reset mid-stream discards buffered bytes; nothing is emitted for them.
- Window: 4-byte shift register w0 (newest) .. w3 (oldest) plus fill counter 0..4.
- Accept (clk_en && byte_in_en && !end_latched):
  - If fill<4: shift byte in, fill+1, nothing emitted.
  - If fill==4: emit w3 registered next cycle (byte_out_en=1, latency 1 clk from the accepting edge), then shift byte in; fill stays 4.
  - Effective delay: byte n emitted on the accept of byte n+4.
- Detection is evaluated on the emitted w3 only:
  - sc_start = (w3==00 && w2==00 && w1==01).
  - sc_code = w0, and sc_video is computed from it.
  - Each emitted byte needs all of w2..w0 valid for detection. Bytes emitted while fewer than 3 newer bytes remain never flag.
  - Zero stuffing (00 00 00 01 xx): the flag lands on the second-to-last 00 before 01, i.e. exactly one flag per prefix.
- End handling:
  - stream_end sampled with clk_en sets end_latched. A byte_in_en on the same cycle is accepted first.
  - byte_in_en after end_latched is ignored until reset.
  - Flush: each clk_en cycle after end_latched with fill>0 emits w3 (detection as above using remaining valid bytes), shifts the window and decrements fill.
  - done goes to 1 the cycle after the last flush emission, or the cycle after end_latched if fill==0.
- Counters:
  - sc_cnt increments on each emitted byte with sc_start.
  - video_sc_cnt increments additionally when sc_video=1.
  - Both update in the same cycle as the flagged byte_out_en.
  - Both wrap modulo 2^CNT_W.
- Output pacing: at most one byte_out_en per clk cycle; output rate equals input rate in steady state.

Test Plan:
- Reset, feed 00 00 01 B3 11 22 33 44, then stream_end:
  - 8 bytes out in order.
  - Byte 0 flagged: sc_start=1, sc_code=B3, sc_video=0.
  - sc_cnt=1, video_sc_cnt=0, done=1 after the 8th byte.
- Feed 00 00 00 01 E0 AA BB CC + end:
  - Only byte index 1 flagged, with sc_code=E0, sc_video=1.
  - video_sc_cnt=1.
- Feed 00 00 01 on its own with stream_end on the last byte:
  - 3 bytes flushed on 3 consecutive cycles, no flag (code byte missing).
  - done the cycle after.
- Toggle clk_en low for 5 cycles mid-stream while byte_in_en=1:
  - No bytes accepted or emitted during that time; the window is unchanged.
  - Stream resumes bit-exact afterwards.
- Assert rst with fill=3 and a pending end:
  - All outputs and counters are 0 the next cycle.
  - A new stream 00 00 01 BA 00 00 01 E0 + end yields flags at bytes 0 and 4, sc_cnt=2, video_sc_cnt=1.
- Assert stream_end with an empty window:
  - done=1 one cycle later.
  - byte_out_en is never asserted.
